// File: rtl/key_evt_pkg.sv
// ============================================================================
// Module : key_evt_pkg
// Brief  : Shared constants and event record for the key event front end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_evt_pkg;

  localparam int NKEYS_DEFAULT = 18;
  localparam int KEY_IDX_W     = $clog2(NKEYS_DEFAULT);

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key_idx;
    logic                 press;
  } key_event_t;

endpackage

`default_nettype wire

// File: rtl/key_event_arbiter_tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : Free-running divider producing a one-cycle sample tick every TICK_DIV clocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 65536
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/key_event_arbiter.sv
// ============================================================================
// Module : key_event_arbiter
// Brief  : Per-key sync/debounce/edge detect with round-robin event stream output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int NKEYS        = NKEYS_DEFAULT,
  parameter int TICK_DIV     = 65536,
  parameter int STABLE_TICKS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NKEYS-1:0]                     key_in,
  output logic [NKEYS-1:0]                     key_state,
  output logic                                 ev_valid,
  input  logic                                 ev_ready,
  output logic [((NKEYS > 1) ? $clog2(NKEYS) : 1)-1:0] ev_key,
  output logic                                 ev_press,
  output logic                                 ev_overrun,
  input  logic                                 clr_overrun
);

  localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;

  logic [NKEYS-1:0] meta_q, sync_q;
  logic [NKEYS-1:0] state_q, state_d;
  logic [3:0]       cnt_q [NKEYS];
  logic [3:0]       cnt_d [NKEYS];
  logic [NKEYS-1:0] post;
  logic [NKEYS-1:0] pend_q, pend_d, dir_q, dir_d;
  logic [KW-1:0]    rr_q, rr_d, key_q, key_d;
  logic             valid_q, valid_d, press_q, press_d, ovr_q, ovr_d, ovr_set;
  logic             tick, load, gnt_found, gnt;
  logic [KW-1:0]    gnt_idx;

  // First requester at or above ptr, wrapping past NKEYS-1 back to 0.
  function automatic logic [KW:0] rr_pick(input logic [NKEYS-1:0] req,
                                          input logic [KW-1:0]    ptr);
    logic          found;
    logic [KW-1:0] idx;
    logic [KW-1:0] kk;
    int            k;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < NKEYS; j++) begin
      k = int'(ptr) + j;
      if (k >= NKEYS) k = k - NKEYS;
      kk = KW'(k);
      if (!found && req[kk]) begin
        found = 1'b1;
        idx   = kk;
      end
    end
    return {found, idx};
  endfunction

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    post    = '0;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] + 4'd1 == 4'(STABLE_TICKS)) begin
          cnt_d[i]   = '0;
          state_d[i] = ~state_q[i];
          post[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign {gnt_found, gnt_idx} = rr_pick(pend_q, rr_q);
  assign load = !valid_q || ev_ready;
  assign gnt  = load && gnt_found;

  // A post in the grant cycle re-arms pend; the granted event keeps the old dir.
  always_comb begin
    pend_d  = pend_q;
    dir_d   = dir_q;
    ovr_set = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (gnt && gnt_idx == KW'(i)) pend_d[i] = 1'b0;
      if (post[i]) begin
        pend_d[i] = 1'b1;
        dir_d[i]  = state_d[i];
        if (pend_q[i] && !(gnt && gnt_idx == KW'(i))) ovr_set = 1'b1;
      end
    end
    ovr_d = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : ovr_q);
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    press_d = press_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        key_d   = gnt_idx;
        press_d = dir_q[gnt_idx];
        rr_d    = (gnt_idx == KW'(NKEYS - 1)) ? '0 : gnt_idx + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      state_q <= '0;
      pend_q  <= '0;
      dir_q   <= '0;
      rr_q    <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      press_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
    end else begin
      meta_q  <= key_in;
      sync_q  <= meta_q;
      state_q <= state_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      rr_q    <= rr_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      press_q <= press_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < NKEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_state  = state_q;
  assign ev_valid   = valid_q;
  assign ev_key     = key_q;
  assign ev_press   = press_q;
  assign ev_overrun = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
// ============================================================================
// Module : tb_key_event_arbiter
// Brief  : Directed self-checking bench for key_event_arbiter (TICK_DIV=4, STABLE_TICKS=3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_event_arbiter;
  import key_evt_pkg::*;

  localparam int NK = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_state;
  logic          ev_valid;
  logic          ev_ready = 1'b0;
  logic [4:0]    ev_key;
  logic          ev_press;
  logic          ev_overrun;
  logic          clr_overrun = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  key_event_arbiter #(.NKEYS(NK), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_state   (key_state),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_key      (ev_key),
    .ev_press    (ev_press),
    .ev_overrun  (ev_overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic key_event_t mk(input int k, input logic p);
    key_event_t e;
    e.key_idx = 5'(k);
    e.press   = p;
    return e;
  endfunction

  task automatic chk_ev(input string tag, input key_event_t e);
    chk(tag, 32'({ev_valid, ev_key, ev_press}), 32'({1'b1, e}));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (ev_valid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
  endtask

  task automatic wait_state(input string tag, input int idx, input logic val, input int max);
    int n = 0;
    while (key_state[idx] !== val && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_state"}, 32'(key_state[idx]), 32'(val));
  endtask

  int keys6[12] = '{0, 5, 6, 9, 10, 11, 12, 13, 14, 15, 16, 17};

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_key", 32'(ev_key), 32'd0);
    chk("rst_press", 32'(ev_press), 32'd0);
    chk("rst_ovr", 32'(ev_overrun), 32'd0);
    chk("rst_state", 32'(key_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(2);

    // 1: single press, held until consumed
    key_in[5] = 1'b1;
    cyc(6);
    chk("s1_early", 32'(key_state[5]), 32'd0);
    wait_state("s1", 5, 1'b1, 40);
    chk("s1_lat", 32'(ev_valid), 32'd0);
    @(negedge clk);
    chk_ev("s1_ev", mk(5, 1'b1));
    cyc(5);
    chk_ev("s1_hold", mk(5, 1'b1));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    chk("s1_drop", 32'(ev_valid), 32'd0);
    cyc(20);
    chk("s1_once", 32'(ev_valid), 32'd0);

    // 2: two glitches of two ticks each must not accumulate
    for (int g = 0; g < 2; g++) begin
      key_in[2] = 1'b1;
      cyc(8);
      key_in[2] = 1'b0;
      cyc(16);
    end
    chk("s2_state", 32'(key_state[2]), 32'd0);
    chk("s2_noev", 32'(ev_valid), 32'd0);

    // set rr pointer to 8 via a key 7 press
    ev_ready = 1'b1;
    key_in[7] = 1'b1;
    wait_valid("p7", 40);
    chk_ev("p7_ev", mk(7, 1'b1));
    @(negedge clk);

    // 3: simultaneous toggles of 0, 7, 17 from rr pointer 8
    key_in[0] = 1'b1; key_in[17] = 1'b1; key_in[7] = 1'b0;
    wait_valid("s3", 40);
    chk_ev("s3_a", mk(17, 1'b1));
    @(negedge clk);
    chk_ev("s3_b", mk(0, 1'b1));
    @(negedge clk);
    chk_ev("s3_c", mk(7, 1'b0));
    @(negedge clk);
    chk("s3_idle", 32'(ev_valid), 32'd0);
    key_in[6] = 1'b1; key_in[9] = 1'b1;
    wait_valid("s3p", 40);
    chk_ev("s3p_a", mk(9, 1'b1));
    @(negedge clk);
    chk_ev("s3p_b", mk(6, 1'b1));
    @(negedge clk);
    chk("s3_ovr", 32'(ev_overrun), 32'd0);

    // 4: overrun of the pending slot while the output is stalled
    ev_ready = 1'b0;
    key_in[3] = 1'b1;
    wait_valid("s4", 40);
    chk_ev("s4_first", mk(3, 1'b1));
    key_in[3] = 1'b0;
    wait_state("s4r", 3, 1'b0, 40);
    chk("s4_noovr", 32'(ev_overrun), 32'd0);
    key_in[3] = 1'b1;
    wait_state("s4p", 3, 1'b1, 40);
    chk("s4_ovr", 32'(ev_overrun), 32'd1);
    key_in[3] = 1'b0;
    wait_state("s4r2", 3, 1'b0, 40);
    chk_ev("s4_held", mk(3, 1'b1));
    ev_ready = 1'b1;
    @(negedge clk);
    chk_ev("s4_second", mk(3, 1'b0));
    @(negedge clk);
    ev_ready = 1'b0;
    chk("s4_idle", 32'(ev_valid), 32'd0);
    chk("s4_sticky", 32'(ev_overrun), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("s4_clr", 32'(ev_overrun), 32'd0);

    // 5: stalled output stays stable while another key becomes pending
    key_in[10] = 1'b1;
    wait_valid("s5", 40);
    key_in[11] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk_ev("s5_stable", mk(10, 1'b1));
      @(negedge clk);
    end
    ev_ready = 1'b1;
    @(negedge clk);
    chk_ev("s5_next", mk(11, 1'b1));
    @(negedge clk);
    ev_ready = 1'b0;
    chk("s5_idle", 32'(ev_valid), 32'd0);

    // 6: async reset with one presented and four pending events
    key_in[16:12] = '1;
    wait_valid("s6", 40);
    chk_ev("s6_pre", mk(12, 1'b1));
    cyc(3);
    #2 rst = 1'b0;
    #1;
    chk("s6_valid", 32'(ev_valid), 32'd0);
    chk("s6_key", 32'(ev_key), 32'd0);
    chk("s6_press", 32'(ev_press), 32'd0);
    chk("s6_ovr", 32'(ev_overrun), 32'd0);
    chk("s6_state", 32'(key_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ev_ready = 1'b1;
    cyc(6);
    chk("s6_quiet", 32'(ev_valid), 32'd0);
    wait_valid("s6post", 40);
    for (int i = 0; i < 12; i++) begin
      chk_ev("s6_ev", mk(keys6[i], 1'b1));
      @(negedge clk);
    end
    chk("s6_idle", 32'(ev_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
